// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared op encodings and default geometry for the FIFO controller.
package fifo_ctrl_pkg;
    typedef enum logic [1:0] {OP_NONE = 2'd0, OP_WR = 2'd1, OP_RD = 2'd2} op_t;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_SIZE  = 1024;
    localparam int DEF_AW    = 10;
endpackage

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: FIFO controller driving an external single-port memory, one access per cycle.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int width = DEF_WIDTH,
    parameter int size  = DEF_SIZE,
    parameter int aw    = DEF_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [width-1:0] push_data,
    output logic             push_ready,
    input  logic             pop,
    output logic             pop_ready,
    output logic [width-1:0] pop_data,
    output logic             pop_valid,
    output logic             full,
    output logic             empty,
    output logic [aw:0]      count,
    output logic             wen,
    output logic             ren,
    output logic [aw-1:0]    Addr,
    inout  wire  [width-1:0] Data
);
    op_t             op, op_nxt;
    logic [aw-1:0]   wr_ptr, rd_ptr;
    logic [aw:0]     count_nxt;
    logic [width-1:0] wdata;
    logic            rr_push, push_elig, pop_elig, push_grant, pop_grant;

    // rr_push set means the next push/pop conflict goes to push
    assign push_elig  = push && !full;
    assign pop_elig   = pop && !empty;
    assign push_grant = push_elig && (!pop_elig || rr_push);
    assign pop_grant  = pop_elig && (!push_elig || !rr_push);
    assign push_ready = !full && !pop_grant;
    assign pop_ready  = !empty && !push_grant;
    assign count_nxt  = count + (aw+1)'(push_grant) - (aw+1)'(pop_grant);
    assign Data       = wen ? wdata : {width{1'bz}};

    always_ff @(posedge clk or posedge rst)
        if (rst) op <= OP_NONE;
        else     op <= op_nxt;

    always_comb op_nxt = push_grant ? OP_WR : pop_grant ? OP_RD : OP_NONE;

    always_comb begin
        wen = op == OP_WR;
        ren = op == OP_RD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            Addr      <= '0;
            wdata     <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            rr_push   <= 1'b0;
            pop_valid <= 1'b0;
            pop_data  <= '0;
        end else begin
            if (push_grant) begin
                Addr   <= wr_ptr;
                wdata  <= push_data;
                wr_ptr <= wr_ptr + aw'(1);
            end
            if (pop_grant) begin
                Addr   <= rd_ptr;
                rd_ptr <= rd_ptr + aw'(1);
            end
            if (push_elig && pop_elig) rr_push <= pop_grant;
            count     <= count_nxt;
            empty     <= count_nxt == '0;
            full      <= count_nxt == (aw+1)'(size);
            pop_valid <= ren;
            if (ren) pop_data <= Data;
        end
    end
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed table, corner sequences and random traffic against a queue model.
module tb_fifo_ctrl;
    localparam int SIZE = 1024;

    logic        clk = 1'b0, rst = 1'b0, push = 1'b0, pop = 1'b0;
    logic [7:0]  push_data = '0;
    logic        push_ready, pop_ready, pop_valid, full, empty, wen, ren;
    logic [7:0]  pop_data;
    logic [10:0] count;
    logic [9:0]  Addr;
    wire  [7:0]  Data;
    logic [7:0]  mem [SIZE];

    fifo_ctrl dut (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data), .push_ready(push_ready),
        .pop(pop), .pop_ready(pop_ready), .pop_data(pop_data), .pop_valid(pop_valid),
        .full(full), .empty(empty), .count(count), .wen(wen), .ren(ren),
        .Addr(Addr), .Data(Data)
    );

    always #5 clk = ~clk;

    // simple external memory: combinational read, write on the clock edge
    assign Data = ren ? mem[Addr] : 8'hzz;
    always @(posedge clk) if (wen) mem[Addr] <= Data;

    int         n_cmp = 0, n_bad = 0;
    logic [7:0] mq[$];
    int         wr_n, rd_n, exp_addr;
    bit         rr_push_m, prev_pop;
    logic [7:0] prev_word;

    typedef struct {
        logic p; logic [7:0] d; logic q;
        logic wen, ren; logic [9:0] addr; logic [10:0] cnt; logic vld; logic [7:0] pd;
    } vec_t;
    vec_t tv[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        wr_n = 0; rd_n = 0; exp_addr = 0;
        rr_push_m = 1'b0; prev_pop = 1'b0; prev_word = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; push = 1'b0; pop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wen", wen, 0);
        chk("rst_ren", ren, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_pop_valid", pop_valid, 0);
        chk("rst_pop_data", pop_data, 0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cycle(input logic p, input logic [7:0] d, input logic q);
        bit fm, em, pe, oe, pg, og;
        logic [7:0] w;
        w = '0;
        push = p; push_data = d; pop = q;
        #1;
        fm = mq.size() == SIZE;
        em = mq.size() == 0;
        pe = p && !fm;
        oe = q && !em;
        pg = pe && (!oe || rr_push_m);
        og = oe && !pg;
        chk("push_ready", push_ready, 32'(!fm && !og));
        chk("pop_ready", pop_ready, 32'(!em && !pg));
        @(posedge clk);
        #1;
        if (pe && oe) rr_push_m = og;
        if (pg) begin mq.push_back(d); exp_addr = wr_n; wr_n = (wr_n + 1) % SIZE; end
        if (og) begin w = mq.pop_front(); exp_addr = rd_n; rd_n = (rd_n + 1) % SIZE; end
        chk("wen", wen, 32'(pg));
        chk("ren", ren, 32'(og));
        chk("wen_ren_excl", 32'(wen && ren), 0);
        if (pg || og) chk("addr", Addr, exp_addr);
        if (pg) chk("wr_data", Data, d);
        chk("count", count, mq.size());
        chk("full", full, 32'(mq.size() == SIZE));
        chk("empty", empty, 32'(mq.size() == 0));
        chk("pop_valid", pop_valid, 32'(prev_pop));
        if (prev_pop) chk("pop_data", pop_data, prev_word);
        prev_pop = og;
        prev_word = w;
    endtask

    initial begin
        tv[0] = '{1'b1, 8'h8c, 1'b0, 1'b1, 1'b0, 10'h000, 11'd1, 1'b0, 8'h00};
        tv[1] = '{1'b1, 8'ha4, 1'b0, 1'b1, 1'b0, 10'h001, 11'd2, 1'b0, 8'h00};
        tv[2] = '{1'b1, 8'h2c, 1'b0, 1'b1, 1'b0, 10'h002, 11'd3, 1'b0, 8'h00};
        tv[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 10'h000, 11'd2, 1'b0, 8'h00};
        tv[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 10'h001, 11'd1, 1'b1, 8'h8c};
        tv[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 10'h002, 11'd0, 1'b1, 8'ha4};
        tv[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'h002, 11'd0, 1'b1, 8'h2c};
        tv[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'h002, 11'd0, 1'b0, 8'h2c};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(tv[i].p, tv[i].d, tv[i].q);
            chk("tv_wen", wen, tv[i].wen);
            chk("tv_ren", ren, tv[i].ren);
            chk("tv_addr", Addr, tv[i].addr);
            chk("tv_count", count, tv[i].cnt);
            chk("tv_valid", pop_valid, tv[i].vld);
            chk("tv_pop_data", pop_data, tv[i].pd);
        end
        chk("tv_empty", empty, 1);

        // fill to full, then pop one and push a word that lands at the wrapped address
        do_reset();
        for (int i = 0; i < SIZE; i++) cycle(1'b1, 8'($urandom), 1'b0);
        chk("fill_full", full, 1);
        push = 1'b1; #1;
        chk("fill_push_ready", push_ready, 0);
        cycle(1'b1, 8'hee, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h5a, 1'b0);
        chk("wrap_addr", Addr, 0);
        chk("wrap_count", count, SIZE);

        // round-robin under sustained conflict starting from a fresh reset
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(i + 8'h30), 1'b0);
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 8'(k + 8'h40), 1'b1);
            chk("rr_ren", ren, 32'(k % 2 == 0));
            chk("rr_count", count, (k % 2 == 0) ? 4 : 5);
        end

        // random traffic, push-biased then pop-biased
        for (int i = 0; i < 3000; i++)
            cycle(1'($urandom_range(0, 99) < (i < 1500 ? 70 : 30)), 8'($urandom),
                  1'($urandom_range(0, 99) < (i < 1500 ? 40 : 70)));

        // asynchronous reset in the middle of a WR cycle
        do_reset();
        cycle(1'b1, 8'h77, 1'b0);
        push = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("abort_wen", wen, 0);
        chk("abort_count", count, 0);
        chk("abort_empty", empty, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("abort_after_data", pop_data, 8'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
